// File: rtl/cyclic_encoder_param.sv
// Serial systematic cyclic encoder: passes K message bits through MSB first,
// then appends the R-bit remainder of msg*x^R mod g(x), MSB first.
module cyclic_encoder_param #(
    parameter int             R    = 3,
    parameter logic [R-1:0]   POLY = 3'b011,
    parameter int             K    = 4,
    parameter int             CW   = $clog2(K + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic din_valid,
    input  logic datain,
    output logic dataout,
    output logic dout_valid,
    output logic busy,
    output logic done
);

    localparam int            PW     = $clog2(R);
    localparam logic [CW-1:0] K_LAST = CW'(K - 1);
    localparam logic [PW-1:0] P_LAST = PW'(R - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2
    } state_t;

    // One division step: shift the remainder and fold in g(x) when the feedback bit is set.
    function automatic logic [R-1:0] lfsr_step(input logic [R-1:0] s, input logic b);
        logic fb;
        fb = s[R-1] ^ b;
        return {s[R-2:0], 1'b0} ^ (fb ? POLY : {R{1'b0}});
    endfunction

    state_t        r_state;
    state_t        w_state_nxt;
    logic [R-1:0]  r_lfsr;
    logic [R-1:0]  w_lfsr_nxt;
    logic [CW-1:0] r_kcnt;
    logic [CW-1:0] w_kcnt_nxt;
    logic [PW-1:0] r_pcnt;
    logic [PW-1:0] w_pcnt_nxt;
    logic          r_dataout;
    logic          w_dataout_nxt;
    logic          r_dout_valid;
    logic          w_dout_valid_nxt;
    logic          r_busy;
    logic          w_busy_nxt;
    logic          r_done;
    logic          w_done_nxt;

    // Next-state and next-output logic for the IDLE/DATA/PARITY sequence.
    always_comb begin
        w_state_nxt      = r_state;
        w_lfsr_nxt       = r_lfsr;
        w_kcnt_nxt       = r_kcnt;
        w_pcnt_nxt       = r_pcnt;
        w_dataout_nxt    = r_dataout;
        w_dout_valid_nxt = 1'b0;
        w_done_nxt       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_lfsr_nxt = {R{1'b0}};
                w_kcnt_nxt = {CW{1'b0}};
                w_pcnt_nxt = {PW{1'b0}};
                if (start) begin
                    w_state_nxt = S_DATA;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DATA: begin
                if (din_valid) begin
                    w_lfsr_nxt       = lfsr_step(r_lfsr, datain);
                    w_dataout_nxt    = datain;
                    w_dout_valid_nxt = 1'b1;
                    // kcnt saturates at K-1 on the way into PARITY; IDLE clears it.
                    if (r_kcnt == K_LAST) begin
                        w_state_nxt = S_PARITY;
                    end else begin
                        w_kcnt_nxt = r_kcnt + CW'(1);
                    end
                end else begin
                    w_dout_valid_nxt = 1'b0;
                end
            end
            S_PARITY: begin
                w_dataout_nxt    = r_lfsr[R-1];
                w_lfsr_nxt       = {r_lfsr[R-2:0], 1'b0};
                w_dout_valid_nxt = 1'b1;
                if (r_pcnt == P_LAST) begin
                    w_done_nxt  = 1'b1;
                    w_pcnt_nxt  = {PW{1'b0}};
                    w_state_nxt = S_IDLE;
                end else begin
                    w_pcnt_nxt = r_pcnt + PW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_lfsr_nxt  = {R{1'b0}};
                w_kcnt_nxt  = {CW{1'b0}};
                w_pcnt_nxt  = {PW{1'b0}};
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_lfsr       <= {R{1'b0}};
            r_kcnt       <= {CW{1'b0}};
            r_pcnt       <= {PW{1'b0}};
            r_dataout    <= 1'b0;
            r_dout_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_lfsr       <= w_lfsr_nxt;
            r_kcnt       <= w_kcnt_nxt;
            r_pcnt       <= w_pcnt_nxt;
            r_dataout    <= w_dataout_nxt;
            r_dout_valid <= w_dout_valid_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
        end
    end

    assign dataout    = r_dataout;
    assign dout_valid = r_dout_valid;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_cyclic_encoder_param.sv
// Bench for cyclic_encoder_param: directed table, hand sequences and random
// messages checked against a polynomial long-division reference.
module tb_cyclic_encoder_param;

    logic clk;
    logic rst;
    logic start_a, din_valid_a, datain_a;
    logic dataout_a, dout_valid_a, busy_a, done_a;
    logic start_b, din_valid_b, datain_b;
    logic dataout_b, dout_valid_b, busy_b, done_b;

    int checks;
    int errors;

    cyclic_encoder_param dut_a (
        .clk(clk), .rst(rst), .start(start_a), .din_valid(din_valid_a), .datain(datain_a),
        .dataout(dataout_a), .dout_valid(dout_valid_a), .busy(busy_a), .done(done_a)
    );

    cyclic_encoder_param #(.R(8), .POLY(8'h07), .K(8)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .din_valid(din_valid_b), .datain(datain_b),
        .dataout(dataout_b), .dout_valid(dout_valid_b), .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Reference: codeword = msg*x^R + (msg*x^R mod g), by long division.
    function automatic logic [63:0] ref_cw(input logic [63:0] msg, input int k, input int r,
                                           input logic [63:0] poly);
        logic [63:0] d;
        logic [63:0] g;
        d = msg << r;
        g = (64'd1 << r) | poly;
        for (int i = k + r - 1; i >= r; i--) begin
            if (d[i]) d = d ^ (g << (i - r));
        end
        return (msg << r) | d;
    endfunction

    bit q_a[$];
    bit q_b[$];
    int done_cnt_a, done_cnt_b;
    int done_idx_a, done_idx_b;
    bit prev_done_a, prev_done_b;

    always @(negedge clk) begin
        if (dout_valid_a) q_a.push_back(dataout_a);
        if (done_a) begin
            done_cnt_a++;
            done_idx_a = q_a.size();
        end
        if (prev_done_a) chk("busy_a_after_done", {63'd0, busy_a}, 64'd0);
        prev_done_a = done_a;
        if (dout_valid_b) q_b.push_back(dataout_b);
        if (done_b) begin
            done_cnt_b++;
            done_idx_b = q_b.size();
        end
        if (prev_done_b) chk("busy_b_after_done", {63'd0, busy_b}, 64'd0);
        prev_done_b = done_b;
    end

    function automatic logic [63:0] pack_q(input bit q[$]);
        logic [63:0] v;
        v = 64'd0;
        foreach (q[i]) v = (v << 1) | {63'd0, q[i]};
        return v;
    endfunction

    typedef struct {
        logic [3:0] msg;
        int         stall_after;
        int         stall_len;
        bit         junk;
        bit         pstart;
        logic [6:0] exp;
    } vec_t;

    task automatic send_a(input logic [3:0] msg, input int stall_after, input int stall_len,
                          input bit junk, input bit pstart, input logic [6:0] exp, input string tag);
        int c;
        q_a.delete();
        done_cnt_a = 0;
        done_idx_a = -1;
        @(negedge clk);
        start_a = 1'b1; din_valid_a = junk; datain_a = junk;
        @(negedge clk);
        start_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == stall_after) begin
                din_valid_a = 1'b0;
                repeat (stall_len) @(negedge clk);
            end
            din_valid_a = 1'b1;
            datain_a = msg[3-i];
            @(negedge clk);
        end
        din_valid_a = 1'b0;
        if (pstart) begin
            start_a = 1'b1; din_valid_a = 1'b1; datain_a = 1'b1;
            @(negedge clk);
            start_a = 1'b0; din_valid_a = 1'b0; datain_a = 1'b0;
        end
        c = 0;
        while (done_cnt_a == 0 && c < 40) begin
            @(negedge clk);
            c++;
        end
        repeat (6) @(negedge clk);
        chk({tag, "_len"},  64'(q_a.size()), 64'd7);
        chk({tag, "_cw"},   pack_q(q_a), {57'd0, exp});
        chk({tag, "_done"}, 64'(done_cnt_a), 64'd1);
        chk({tag, "_done_at_last"}, 64'(done_idx_a), 64'd7);
        chk({tag, "_busy_idle"}, {63'd0, busy_a}, 64'd0);
    endtask

    task automatic send_b(input logic [7:0] msg, input logic [15:0] exp, input string tag);
        int c;
        q_b.delete();
        done_cnt_b = 0;
        done_idx_b = -1;
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        chk({tag, "_busy_start"}, {63'd0, busy_b}, 64'd1);
        for (int i = 0; i < 8; i++) begin
            din_valid_b = 1'b1;
            datain_b = msg[7-i];
            @(negedge clk);
        end
        din_valid_b = 1'b0;
        c = 0;
        while (done_cnt_b == 0 && c < 40) begin
            @(negedge clk);
            c++;
        end
        repeat (3) @(negedge clk);
        chk({tag, "_len"},  64'(q_b.size()), 64'd16);
        chk({tag, "_cw"},   pack_q(q_b), {48'd0, exp});
        chk({tag, "_done"}, 64'(done_cnt_b), 64'd1);
        chk({tag, "_done_at_last"}, 64'(done_idx_b), 64'd16);
    endtask

    initial begin
        vec_t vecs[4];
        logic [3:0] m4;
        logic [7:0] m8;
        logic [63:0] e;
        checks = 0;
        errors = 0;
        vecs[0] = '{4'b1101, -1, 0, 1'b0, 1'b0, 7'b1101001};
        vecs[1] = '{4'b1000,  2, 2, 1'b0, 1'b0, 7'b1000101};
        vecs[2] = '{4'b0000, -1, 0, 1'b0, 1'b1, 7'b0000000};
        vecs[3] = '{4'b1000, -1, 0, 1'b1, 1'b0, 7'b1000101};

        rst = 1'b0;
        start_a = 1'b0; din_valid_a = 1'b0; datain_a = 1'b0;
        start_b = 1'b0; din_valid_b = 1'b0; datain_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_a_outs", {60'd0, dataout_a, dout_valid_a, busy_a, done_a}, 64'd0);
        chk("rst_b_outs", {60'd0, dataout_b, dout_valid_b, busy_b, done_b}, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            send_a(vecs[i].msg, vecs[i].stall_after, vecs[i].stall_len,
                   vecs[i].junk, vecs[i].pstart, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Reset after two data bits abandons the codeword.
        q_a.delete();
        done_cnt_a = 0;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        din_valid_a = 1'b1; datain_a = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("midrst_outs", {60'd0, dataout_a, dout_valid_a, busy_a, done_a}, 64'd0);
        q_a.delete();
        repeat (8) @(negedge clk);
        din_valid_a = 1'b0;
        chk("midrst_no_done", 64'(done_cnt_a), 64'd0);
        chk("midrst_no_out", 64'(q_a.size()), 64'd0);
        chk("midrst_idle", {63'd0, busy_a}, 64'd0);
        send_a(4'b1101, -1, 0, 1'b0, 1'b0, 7'b1101001, "after_rst");

        send_b(8'h01, 16'h0107, "r8_01");

        for (int n = 0; n < 12; n++) begin
            m4 = 4'($urandom_range(0, 15));
            e = ref_cw({60'd0, m4}, 4, 3, 64'h3);
            send_a(m4, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e[6:0],
                   $sformatf("rnd_a%0d", n));
        end
        for (int n = 0; n < 6; n++) begin
            m8 = 8'($urandom_range(0, 255));
            e = ref_cw({56'd0, m8}, 8, 8, 64'h07);
            send_b(m8, e[15:0], $sformatf("rnd_b%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
